// File: rtl/mac_operand_loader_pkg.sv
// Shared definitions for the matrix accelerator operand path.
// Holds the beat/row geometry, the loader state encoding and the per-tile mode bundle.
package mac_operand_loader_pkg;

  localparam int unsigned WORD_W        = 24;    // stream beat width, divides ROW_W
  localparam int unsigned ROW_W         = 264;   // bits per operand row
  localparam int unsigned A_ROWS        = 16;    // rows in a_vec
  localparam int unsigned BEATS_PER_ROW = ROW_W / WORD_W;                // 11
  localparam int unsigned TILE_BEATS    = (A_ROWS + 1) * BEATS_PER_ROW;  // 187
  localparam int unsigned TILE_W        = (A_ROWS + 1) * ROW_W;          // {a_vec, b_vec}
  localparam int unsigned BEAT_IDX_W    = $clog2(TILE_BEATS);

  localparam logic [BEAT_IDX_W-1:0] LAST_BEAT = BEAT_IDX_W'(TILE_BEATS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StIssue,
    StBusy
  } state_e;

  typedef struct packed {
    logic mode_int8;
    logic mode_int4;
    logic mode_vsq;
  } tile_cfg_t;

endpackage

// File: rtl/mac_operand_loader_operand_row_packer.sv
// Tile staging buffer with per-beat write-enable decode.
// Beat n lands at bits [24n+23:24n] of the concatenated {a_vec, b_vec} image, which
// gives exactly the b_vec-first, then row-major a_vec ordering of the stream.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset (clears the buffer)
//   we          write the current beat
//   beat_idx    beat position within the tile, 0..TILE_BEATS-1
//   data        beat payload
//   tile_next   buffer contents including this cycle's write (next-state view)
module operand_row_packer
  import mac_operand_loader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [BEAT_IDX_W-1:0] beat_idx,
  input  logic [WORD_W-1:0]     data,
  output logic [TILE_W-1:0]     tile_next
);

  logic [TILE_W-1:0] tile_q;

  always_comb begin
    tile_next = tile_q;
    for (int unsigned i = 0; i < TILE_BEATS; i++) begin
      if (we && (beat_idx == BEAT_IDX_W'(i))) begin
        tile_next[i*WORD_W +: WORD_W] = data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tile_q <= '0;
    end else begin
      tile_q <= tile_next;
    end
  end

endmodule

// File: rtl/mac_operand_loader.sv
// Producer end of the matrix accelerator operand interface.
// Assembles one tile (b_vec row, then 16 a_vec rows) from a valid/ready beat stream,
// latches the per-tile mode bits, pulses valid_mac for one cycle and holds all operands
// stable until the accelerator reports acc_done.
// Optional build macro MAC_OPERAND_LOADER_DBUF_EN: the next tile keeps streaming into the
// staging buffer while the current one is in flight; a complete staged tile is issued in
// the cycle right after acc_done.
// Ports:
//   clk, rst_n                      clock, synchronous active-low reset
//   s_data/s_valid/s_last/s_ready   beat stream from the memory side
//   cfg_int8/cfg_int4/cfg_vsq       tile mode, sampled on the first beat
//   acc_done                        accelerator completion
//   a_vec, b_vec, is_*              registered operands and mode for the accelerator
//   valid_mac                       one-cycle issue pulse
//   busy, err, tile_count           status: in flight, sticky protocol error, issued tiles
module mac_operand_loader
  import mac_operand_loader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [WORD_W-1:0]       s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  input  logic                    cfg_int8,
  input  logic                    cfg_int4,
  input  logic                    cfg_vsq,
  input  logic                    acc_done,
  output logic [A_ROWS*ROW_W-1:0] a_vec,
  output logic [ROW_W-1:0]        b_vec,
  output logic                    is_int8_mode,
  output logic                    is_int4_mode,
  output logic                    is_vsq,
  output logic                    valid_mac,
  output logic                    busy,
  output logic                    err,
  output logic [15:0]             tile_count
);

  state_e                  state_q;
  logic [BEAT_IDX_W-1:0]   beat_cnt_q, beat_cnt_d;
  tile_cfg_t               cfg_stage_q, cfg_out_q;
  logic [A_ROWS*ROW_W-1:0] a_vec_q;
  logic [ROW_W-1:0]        b_vec_q;
  logic                    err_q;
  logic [15:0]             tile_count_q;
  logic [TILE_W-1:0]       tile_next;

`ifdef MAC_OPERAND_LOADER_DBUF_EN
  logic                    shadow_full_q;
`endif

  logic xfer, first_beat, fill_done, fill_abort, load_out;

  assign xfer       = s_valid && s_ready;
  assign first_beat = xfer && (beat_cnt_q == '0);
  assign fill_done  = xfer && (beat_cnt_q == LAST_BEAT);
  assign fill_abort = xfer && (beat_cnt_q != LAST_BEAT) && s_last;

  // Staging buffer; with double buffering it is also the shadow tile, since the output
  // registers already hold the in-flight tile.
  operand_row_packer u_row_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (xfer),
    .beat_idx  (beat_cnt_q),
    .data      (s_data),
    .tile_next (tile_next)
  );

  always_comb begin
    s_ready = 1'b0;
    unique case (state_q)
      StIdle, StFill:  s_ready = 1'b1;
`ifdef MAC_OPERAND_LOADER_DBUF_EN
      StIssue, StBusy: s_ready = !shadow_full_q;
`else
      StIssue, StBusy: s_ready = 1'b0;
`endif
      default:         s_ready = 1'b0;
    endcase
  end

  // The final beat always completes the tile, even without s_last (that only flags err).
  always_comb begin
    beat_cnt_d = beat_cnt_q;
    if (xfer) begin
      if ((beat_cnt_q == LAST_BEAT) || s_last) begin
        beat_cnt_d = '0;
      end else begin
        beat_cnt_d = beat_cnt_q + 1'b1;
      end
    end
  end

  // Copy staging to outputs; tile_next includes a final beat arriving this same cycle.
  always_comb begin
    load_out = ((state_q == StIdle) || (state_q == StFill)) && fill_done;
`ifdef MAC_OPERAND_LOADER_DBUF_EN
    if ((state_q == StBusy) && acc_done && (shadow_full_q || fill_done)) begin
      load_out = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      beat_cnt_q    <= '0;
      cfg_stage_q   <= '0;
      cfg_out_q     <= '0;
      a_vec_q       <= '0;
      b_vec_q       <= '0;
      err_q         <= 1'b0;
      tile_count_q  <= '0;
`ifdef MAC_OPERAND_LOADER_DBUF_EN
      shadow_full_q <= 1'b0;
`endif
    end else begin
      beat_cnt_q <= beat_cnt_d;

      if (first_beat) begin
        cfg_stage_q <= '{mode_int8: cfg_int8, mode_int4: cfg_int4, mode_vsq: cfg_vsq};
      end

      if ((first_beat && cfg_int8 && cfg_int4) || (fill_done && !s_last) || fill_abort) begin
        err_q <= 1'b1;
      end

      if (load_out) begin
        a_vec_q      <= tile_next[TILE_W-1:ROW_W];
        b_vec_q      <= tile_next[ROW_W-1:0];
        cfg_out_q    <= cfg_stage_q;
        tile_count_q <= tile_count_q + 16'd1;
      end

      unique case (state_q)
        StIdle, StFill: begin
          if (load_out) begin
            state_q <= StIssue;
          end else if (xfer) begin
            state_q <= fill_abort ? StIdle : StFill;
          end
        end
        StIssue: begin
          // acc_done is deliberately not looked at here.
          state_q <= StBusy;
`ifdef MAC_OPERAND_LOADER_DBUF_EN
          if (fill_done) begin
            shadow_full_q <= 1'b1;
          end
`endif
        end
        StBusy: begin
`ifdef MAC_OPERAND_LOADER_DBUF_EN
          if (load_out) begin
            state_q       <= StIssue;
            shadow_full_q <= 1'b0;
          end else if (acc_done) begin
            // Resume a partially streamed shadow tile where it left off.
            state_q <= (beat_cnt_d != '0) ? StFill : StIdle;
          end else if (fill_done) begin
            shadow_full_q <= 1'b1;
          end
`else
          if (acc_done) begin
            state_q <= StIdle;
          end
`endif
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign a_vec        = a_vec_q;
  assign b_vec        = b_vec_q;
  assign is_int8_mode = cfg_out_q.mode_int8;
  assign is_int4_mode = cfg_out_q.mode_int4;
  assign is_vsq       = cfg_out_q.mode_vsq;
  assign valid_mac    = (state_q == StIssue);
  assign busy         = (state_q == StIssue) || (state_q == StBusy);
  assign err          = err_q;
  assign tile_count   = tile_count_q;

endmodule

// File: tb/tb_mac_operand_loader.sv
module tb_mac_operand_loader;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [23:0]   s_data;
  logic          s_valid, s_last, s_ready;
  logic          cfg_int8, cfg_int4, cfg_vsq, acc_done;
  logic [4223:0] a_vec;
  logic [263:0]  b_vec;
  logic          is_int8_mode, is_int4_mode, is_vsq;
  logic          valid_mac, busy, err;
  logic [15:0]   tile_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mac_operand_loader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .s_data       (s_data),
    .s_valid      (s_valid),
    .s_last       (s_last),
    .s_ready      (s_ready),
    .cfg_int8     (cfg_int8),
    .cfg_int4     (cfg_int4),
    .cfg_vsq      (cfg_vsq),
    .acc_done     (acc_done),
    .a_vec        (a_vec),
    .b_vec        (b_vec),
    .is_int8_mode (is_int8_mode),
    .is_int4_mode (is_int4_mode),
    .is_vsq       (is_vsq),
    .valid_mac    (valid_mac),
    .busy         (busy),
    .err          (err),
    .tile_count   (tile_count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive beats first..first+count-1, data = offset + index, s_last on beat last_at.
  // Mode bits are presented on beat 0 only and driven 0 afterwards.
  task automatic stream(input int first, input int count, input int last_at,
                        input logic [23:0] offset, input logic c8, input logic c4,
                        input logic cv);
    for (int i = first; i < first + count; i++) begin
      int w;
      s_data   = offset + 24'(i);
      s_last   = (i == last_at);
      cfg_int8 = (i == 0) ? c8 : 1'b0;
      cfg_int4 = (i == 0) ? c4 : 1'b0;
      cfg_vsq  = (i == 0) ? cv : 1'b0;
      s_valid  = 1'b1;
      w = 0;
      while (s_ready !== 1'b1 && w < 500) begin
        step();
        w++;
      end
      if (w >= 500) begin
        checks++;
        errors++;
        $error("FAIL ready_timeout observed=%0d expected=<500", w);
      end
      step();
    end
    s_valid  = 1'b0;
    s_last   = 1'b0;
    cfg_int8 = 1'b0;
    cfg_int4 = 1'b0;
    cfg_vsq  = 1'b0;
  endtask

  task automatic pulse_done();
    acc_done = 1'b1;
    step();
    acc_done = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    cfg_int8 = 1'b0; cfg_int4 = 1'b0; cfg_vsq = 1'b0; acc_done = 1'b0;
    step();
    do_reset();

    // Reset state.
    check("rst_valid_mac", valid_mac, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_tile_count", tile_count, 0);
    check("rst_a_zero", 64'(a_vec === '0), 1);
    check("rst_b_zero", 64'(b_vec === '0), 1);
    check("rst_modes", {is_int8_mode, is_int4_mode, is_vsq}, 0);
    check("rst_s_ready", s_ready, 1);

    // Tile 1: data = beat index, int8+vsq on beat 0. Now in the ISSUE cycle.
    stream(0, 187, 186, 24'h0, 1'b1, 1'b0, 1'b1);
    check("t1_valid_mac", valid_mac, 1);
    check("t1_busy", busy, 1);
    check("t1_s_ready", s_ready, 0);
    check("t1_b_lo", b_vec[23:0], 0);
    check("t1_b_hi", b_vec[263:240], 10);
    check("t1_a_lo", a_vec[23:0], 11);
    check("t1_a_hi", a_vec[4223:4200], 186);
    check("t1_tile_count", tile_count, 1);
    check("t1_err", err, 0);
    check("t1_modes", {is_int8_mode, is_int4_mode, is_vsq}, 3'b101);
    // acc_done during ISSUE must be ignored.
    pulse_done();
    check("t1_pulse_one_cycle", valid_mac, 0);
    check("t1_done_in_issue_ignored", busy, 1);
    check("t1_modes_held", {is_int8_mode, is_int4_mode, is_vsq}, 3'b101);

`ifndef MAC_OPERAND_LOADER_DBUF_EN
    // Beats offered while BUSY are not accepted.
    s_data  = 24'hABCDEF;
    s_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("busy_s_ready", s_ready, 0);
      step();
    end
    s_valid = 1'b0;
    check("busy_b_held", b_vec[23:0], 0);
`endif
    pulse_done();
    check("t1_done_s_ready", s_ready, 1);
    check("t1_done_busy", busy, 0);

    // Tile 2: no mode bits, offset data.
    stream(0, 187, 186, 24'h100, 1'b0, 1'b0, 1'b0);
    check("t2_valid_mac", valid_mac, 1);
    check("t2_b_lo", b_vec[23:0], 24'h100);
    check("t2_b_hi", b_vec[263:240], 24'h10A);
    check("t2_a_lo", a_vec[23:0], 24'h10B);
    check("t2_a_hi", a_vec[4223:4200], 24'h1BA);
    check("t2_tile_count", tile_count, 2);
    check("t2_modes", {is_int8_mode, is_int4_mode, is_vsq}, 3'b000);
    step();
    pulse_done();
    check("t2_idle", busy, 0);

    // Early s_last on beat 50: error, partial tile dropped.
    stream(0, 51, 50, 24'h200, 1'b0, 1'b0, 1'b0);
    check("early_err", err, 1);
    check("early_valid_mac", valid_mac, 0);
    check("early_busy", busy, 0);
    check("early_s_ready", s_ready, 1);
    check("early_b_kept", b_vec[23:0], 24'h100);
    check("early_a_kept", a_vec[4223:4200], 24'h1BA);
    check("early_tile_count", tile_count, 2);
    step();
    check("early_no_issue", valid_mac, 0);

    // Reset while beat 100 is on the bus.
    stream(0, 100, -1, 24'h300, 1'b0, 1'b0, 1'b0);
    s_data  = 24'h300 + 24'd100;
    s_valid = 1'b1;
    rst_n   = 1'b0;
    step();
    s_valid = 1'b0;
    rst_n   = 1'b1;
    check("midrst_a_zero", 64'(a_vec === '0), 1);
    check("midrst_b_zero", 64'(b_vec === '0), 1);
    check("midrst_err", err, 0);
    check("midrst_tile_count", tile_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_valid_mac", valid_mac, 0);
    stream(0, 187, 186, 24'h300, 1'b0, 1'b0, 1'b0);
    check("fresh_valid_mac", valid_mac, 1);
    check("fresh_tile_count", tile_count, 1);
    check("fresh_b_lo", b_vec[23:0], 24'h300);
    check("fresh_a_lo", a_vec[23:0], 24'h30B);
    check("fresh_err", err, 0);
    step();
    pulse_done();

    // Missing s_last on the final beat: still issues, but flags err.
    stream(0, 187, -1, 24'h400, 1'b0, 1'b0, 1'b0);
    check("nolast_valid_mac", valid_mac, 1);
    check("nolast_err", err, 1);
    check("nolast_a_hi", a_vec[4223:4200], 24'h4BA);
    step();
    pulse_done();

    // int8 and int4 together: err, both latched as given.
    do_reset();
    stream(0, 187, 186, 24'h500, 1'b1, 1'b1, 1'b0);
    check("both_valid_mac", valid_mac, 1);
    check("both_err", err, 1);
    check("both_modes", {is_int8_mode, is_int4_mode, is_vsq}, 3'b110);
    step();
    pulse_done();

`ifdef MAC_OPERAND_LOADER_DBUF_EN
    // Back-to-back tiles: the second fills the shadow while the first is in flight.
    do_reset();
    stream(0, 187, 186, 24'h600, 1'b0, 1'b0, 1'b0);
    check("db1_valid_mac", valid_mac, 1);
    check("db1_s_ready", s_ready, 1);
    stream(0, 187, 186, 24'h700, 1'b0, 1'b0, 1'b0);
    check("db_shadow_full_s_ready", s_ready, 0);
    check("db_busy", busy, 1);
    check("db_out_still_t1", b_vec[23:0], 24'h600);
    check("db_tile_count1", tile_count, 1);
    repeat (20) step();
    check("db_no_early_issue", valid_mac, 0);
    pulse_done();
    check("db2_valid_mac", valid_mac, 1);
    check("db2_b_lo", b_vec[23:0], 24'h700);
    check("db2_a_hi", a_vec[4223:4200], 24'h7BA);
    check("db2_tile_count", tile_count, 2);
    step();
    check("db2_pulse_one_cycle", valid_mac, 0);
    pulse_done();
    check("db_idle", busy, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mac_operand_loader.md
Name: mac_operand_loader

Overview:
- Producer end of the matrix accelerator operand interface.
- Accepts a narrow valid/ready beat stream from the memory side and assembles one tile: the 264-bit b_vec row and the 4224-bit a_vec (16 rows × 264 bits).
- Latches the per-tile mode bits, pulses valid_mac for one cycle, and holds all operands stable until the accelerator reports done.
- Sits between the DMA/SRAM read port and the matrix_accelerator top.

Parameters:
- WORD_W, 24, stream beat width; must divide ROW_W.
- ROW_W, 264, bits per operand row.
- A_ROWS, 16, rows in a_vec.
- BEATS_PER_ROW, ROW_W/WORD_W = 11, localparam.
- TILE_BEATS, (A_ROWS+1)*BEATS_PER_ROW = 187, localparam.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- s_data  in  WORD_W  operand beat.
- s_valid  in  1  beat valid.
- s_last  in  1  final beat of tile.
- s_ready  out  1  loader accepts beat.
- cfg_int8  in  1  mode, sampled on first beat of tile.
- cfg_int4  in  1  mode, sampled on first beat of tile.
- cfg_vsq  in  1  mode, sampled on first beat of tile.
- acc_done  in  1  accelerator done_wire.
- a_vec  out  A_ROWS*ROW_W  assembled A operand.
- b_vec  out  ROW_W  assembled B operand.
- is_int8_mode  out  1  latched mode.
- is_int4_mode  out  1  latched mode.
- is_vsq  out  1  latched mode.
- valid_mac  out  1  one-cycle tile-issue pulse.
- busy  out  1  tile in flight.
- err  out  1  sticky protocol error.
- tile_count  out  16  tiles issued, wraps at 65535→0.

Behaviour:
- Reset (synchronous, rst_n=0 at clk edge): all outputs 0; state IDLE; beat counter 0; a_vec/b_vec cleared; err cleared.
- A beat transfers when s_valid && s_ready.
- Beat order:
  - beats 0..10 fill b_vec; beat k goes to bits [24k+23:24k].
  - beats 11..186 fill a_vec; beat n maps to row r=(n-11)/11, k=(n-11)%11, bits [264r+24k+23 : 264r+24k].
- States:
  - IDLE: s_ready=1. The first transfer latches the cfg_* bits, writes beat 0 and moves to FILL.
  - FILL: s_ready=1. One beat written per transfer.
    - On the transfer of beat 186: go to ISSUE, whatever s_last is. If s_last=0 on that beat, set err.
    - s_last=1 on any earlier beat: set err, discard the partial tile (a_vec/b_vec keep their previous contents, no issue), return to IDLE.
  - ISSUE: lasts 1 cycle. valid_mac=1, s_ready=0, busy=1, tile_count increments. Next state BUSY.
  - BUSY: s_ready=0, busy=1. On acc_done=1 go to IDLE.
    - acc_done is ignored in every other state.
    - acc_done in the same cycle as the ISSUE pulse is ignored; done is only honoured from BUSY.
- Outputs stay stable from ISSUE until the BUSY→IDLE transition:
  - a_vec, b_vec and the is_* bits are registered and never change while busy=1.
- Latency: valid_mac rises the cycle after beat 186 transfers. Minimum tile period is 187 + 1 + (accelerator latency) cycles.
- cfg_int8 and cfg_int4 both 1 on the first beat: set err and latch both as given (the accelerator resolves priority).
- Reset mid-FILL or mid-BUSY returns to IDLE immediately. An in-flight accelerator result is abandoned and the next tile starts clean.
- err stays set until reset.

Optional Feature:
- MAC_OPERAND_LOADER_DBUF_EN
- Defined:
  - Adds a shadow tile buffer plus shadow cfg registers.
  - s_ready stays 1 during ISSUE/BUSY, and the next tile fills the shadow buffer.
  - When the shadow is complete, s_ready=0 until acc_done. On acc_done with a complete shadow, the shadow is copied to the outputs and valid_mac pulses in the very next cycle (ISSUE), skipping IDLE.
  - Early s_last while filling the shadow discards the shadow and sets err.
- Undefined: single buffer, behaviour exactly as above.

Decomposition:
- Shared package (accelerator-wide): ROW_W, A_ROWS, WORD_W, the state encoding (IDLE, FILL, ISSUE, BUSY) and the tile-beat localparams.
- One sub-module is natural: operand_row_packer. It takes a beat index and data and performs the write-enable decode into the wide register. It is instanced once, or twice with DBUF.

Test Plan:
- Tile with beat n data = n (24-bit), s_last on beat 186 → valid_mac pulse 1 cycle after; b_vec[23:0]=0, b_vec[263:240]=10, a_vec[23:0]=11, a_vec[4223:4200]=186; tile_count=1; err=0.
- cfg_int8=1, cfg_vsq=1 on the first beat, toggled to 0 afterwards → is_int8_mode=1, is_vsq=1 held through BUSY.
- s_last on beat 50 → err=1, no valid_mac, state IDLE, a_vec/b_vec unchanged from the previous tile.
- s_valid asserted during BUSY (no DBUF) → s_ready=0, no beat consumed. After acc_done, s_ready=1 next cycle and the next tile loads correctly.
- rst_n=0 for 1 cycle at beat 100 → all outputs 0. A fresh full tile then issues with tile_count=1.
- With DBUF: stream two tiles back-to-back, acc_done 20 cycles after the first ISSUE → second valid_mac exactly 1 cycle after acc_done carrying tile-2 data; tile_count=2.
